// File: rtl/led_count_ctrl_if.sv
// led_count_ctrl_if: control inputs and display outputs of the LED counter.
// Latency: none, wiring only.
// Backpressure: none; outputs are plain levels and pulses.
interface led_count_ctrl_if;
   logic       tick_in;
   logic       pause;
   logic       clear;
   logic       up_down;
   logic [6:0] count_bin;
   logic [7:0] leds;
   logic [6:0] hex0;
   logic [6:0] hex1;
   logic       wrap;

   // Driver side: supplies tick/pause/clear/direction, observes the display.
   modport master (
      output tick_in, pause, clear, up_down,
      input  count_bin, leds, hex0, hex1, wrap
   );

   // Counter side.
   modport slave (
      input  tick_in, pause, clear, up_down,
      output count_bin, leds, hex0, hex1, wrap
   );
endinterface

// File: rtl/led_count_ctrl.sv
// led_count_ctrl: two-digit BCD counter stepped by rising edges of a slow tick; drives LEDs and two active-low 7-seg digits.
// Latency: a tick_in rising edge first sampled at edge N updates every output at edge N+3; pause/clear act at the next edge.
// Backpressure: none; steps arriving with pause or clear are dropped. Down-counting is compiled only when LED_COUNT_DOWN_EN is defined.
module led_count_ctrl #(
   parameter int MAX_COUNT = 99
) (
   input  logic            clock_50MHZ,
   input  logic            reset_n,
   led_count_ctrl_if.slave bus
);
   localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);
   localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_prev;
   logic [2:0] r_vld;
   logic       r_step;
   logic [3:0] r_ones;
   logic [3:0] r_tens;
   logic [6:0] r_count_bin;
   logic [6:0] r_hex0;
   logic [6:0] r_hex1;
   logic       r_wrap;
   logic       r_pause_q;

   logic       w_edge;
   logic       w_count_up;
   logic       w_at_max;
   logic [3:0] w_ones_nxt;
   logic [3:0] w_tens_nxt;
   logic       w_wrap_nxt;

   // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles blank the digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

`ifdef LED_COUNT_DOWN_EN
   logic w_at_zero;
   assign w_count_up = bus.up_down;
   assign w_at_zero  = (r_ones == 4'd0) && (r_tens == 4'd0);
`else
   logic w_unused_up_down;
   assign w_count_up       = 1'b1;
   assign w_unused_up_down = bus.up_down;
`endif

   // Synchronise tick_in and keep one history flop; r_vld tracks which stages hold post-reset samples.
   always_ff @(posedge clock_50MHZ or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_vld   <= 3'b000;
      end else begin
         r_sync1 <= bus.tick_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_vld   <= {r_vld[1:0], 1'b1};
      end
   end

   // An edge needs a genuinely sampled low in r_prev, so a tick already high at reset release never counts.
   assign w_edge = r_sync2 & ~r_prev & r_vld[2];

   // Register the edge pulse; the counter consumes it one cycle later, giving the three-edge input latency.
   always_ff @(posedge clock_50MHZ or negedge reset_n) begin
      if (!reset_n) begin
         r_step <= 1'b0;
      end else begin
         r_step <= w_edge;
      end
   end

   assign w_at_max = (r_ones == MAX_ONES) && (r_tens == MAX_TENS);

   // Next count: clear beats pause beats step; wrap flags a real roll-over only.
   always_comb begin
      w_ones_nxt = r_ones;
      w_tens_nxt = r_tens;
      w_wrap_nxt = 1'b0;
      if (bus.clear) begin
         w_ones_nxt = 4'd0;
         w_tens_nxt = 4'd0;
      end else if (!bus.pause && r_step) begin
         if (w_count_up) begin
            if (w_at_max) begin
               w_ones_nxt = 4'd0;
               w_tens_nxt = 4'd0;
               w_wrap_nxt = 1'b1;
            end else if (r_ones == 4'd9) begin
               w_ones_nxt = 4'd0;
               w_tens_nxt = r_tens + 4'd1;
            end else begin
               w_ones_nxt = r_ones + 4'd1;
            end
         end
`ifdef LED_COUNT_DOWN_EN
         else begin
            if (w_at_zero) begin
               w_ones_nxt = MAX_ONES;
               w_tens_nxt = MAX_TENS;
               w_wrap_nxt = 1'b1;
            end else if (r_ones == 4'd0) begin
               w_ones_nxt = 4'd9;
               w_tens_nxt = r_tens - 4'd1;
            end else begin
               w_ones_nxt = r_ones - 4'd1;
            end
         end
`endif
      end
   end

   // Count digits and every display output update together from the next-count value.
   always_ff @(posedge clock_50MHZ or negedge reset_n) begin
      if (!reset_n) begin
         r_ones      <= 4'd0;
         r_tens      <= 4'd0;
         r_count_bin <= 7'd0;
         r_hex0      <= 7'h40;
         r_hex1      <= 7'h40;
         r_wrap      <= 1'b0;
         r_pause_q   <= 1'b0;
      end else begin
         r_ones      <= w_ones_nxt;
         r_tens      <= w_tens_nxt;
         r_count_bin <= 7'(w_tens_nxt) * 7'd10 + 7'(w_ones_nxt);
         r_hex0      <= seg7(w_ones_nxt);
         r_hex1      <= seg7(w_tens_nxt);
         r_wrap      <= w_wrap_nxt;
         r_pause_q   <= bus.pause;
      end
   end

   assign bus.count_bin = r_count_bin;
   assign bus.leds      = {r_pause_q, r_count_bin};
   assign bus.hex0      = r_hex0;
   assign bus.hex1      = r_hex1;
   assign bus.wrap      = r_wrap;
endmodule

// File: tb/tb_led_count_ctrl.sv
// tb_led_count_ctrl: drives two counters (terminal counts 12 and 99) with the same stimulus.
// Outputs are compared every cycle against a count-level reference model, plus literal checks at key points.
// Stimulus: directed reset/latency/wrap/priority sequences, then randomized ticks, pause, clear, direction and resets.
`timescale 1ns/1ps
module tb_led_count_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic tick_r  = 1'b0;
   logic pause_r = 1'b0;
   logic clear_r = 1'b0;
   logic updn_r  = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   led_count_ctrl_if bus_a ();
   led_count_ctrl_if bus_b ();

   assign bus_a.tick_in = tick_r;
   assign bus_a.pause   = pause_r;
   assign bus_a.clear   = clear_r;
   assign bus_a.up_down = updn_r;
   assign bus_b.tick_in = tick_r;
   assign bus_b.pause   = pause_r;
   assign bus_b.clear   = clear_r;
   assign bus_b.up_down = updn_r;

   led_count_ctrl #(.MAX_COUNT(12)) dut_a (
      .clock_50MHZ (clk),
      .reset_n     (rst_n),
      .bus         (bus_a)
   );

   led_count_ctrl dut_b (
      .clock_50MHZ (clk),
      .reset_n     (rst_n),
      .bus         (bus_b)
   );

   // ---------------- reference model ----------------
   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int m_max [2] = '{12, 99};
   int m_cnt [2];
   bit m_wrap [2];
   bit m_pq;
   bit m_pipe [3];
   bit m_last;
   int m_nsamp;

   // A rising edge is two consecutive post-reset samples 0 then 1; its step lands three edges after the 1 is sampled.
   always @(posedge clk) begin
      bit act;
      bit rise;
      bit up;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
         end
         m_pq = 1'b0;
         for (int i = 0; i < 3; i++) m_pipe[i] = 1'b0;
         m_last  = 1'b0;
         m_nsamp = 0;
      end else begin
         act  = m_pipe[2];
         rise = (m_nsamp > 0) && !m_last && tick_r;
         m_pipe[2] = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = rise;
         m_last = tick_r;
         if (m_nsamp < 10) m_nsamp++;
`ifdef LED_COUNT_DOWN_EN
         up = updn_r;
`else
         up = 1'b1;
`endif
         for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 1'b0;
            if (clear_r) m_cnt[i] = 0;
            else if (!pause_r && act) begin
               if (up) begin
                  if (m_cnt[i] == m_max[i]) begin m_cnt[i] = 0; m_wrap[i] = 1'b1; end
                  else m_cnt[i] = m_cnt[i] + 1;
               end else begin
                  if (m_cnt[i] == 0) begin m_cnt[i] = m_max[i]; m_wrap[i] = 1'b1; end
                  else m_cnt[i] = m_cnt[i] - 1;
               end
            end
         end
         m_pq = pause_r;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_inst(input int i, input string p, input logic [6:0] cb, input logic [7:0] ld,
                           input logic [6:0] h0, input logic [6:0] h1, input logic w);
      chk({p, ".count_bin"}, 32'(cb), 32'(m_cnt[i]));
      chk({p, ".leds"},      32'(ld), 32'({m_pq, 7'(m_cnt[i])}));
      chk({p, ".hex0"},      32'(h0), 32'(seg_tab[m_cnt[i] % 10]));
      chk({p, ".hex1"},      32'(h1), 32'(seg_tab[m_cnt[i] / 10]));
      chk({p, ".wrap"},      32'(w),  32'(m_wrap[i]));
   endtask

   // Every cycle, after the edge has settled, both counters must match the model.
   always @(posedge clk) begin
      #2;
      cmp_inst(0, "A", bus_a.count_bin, bus_a.leds, bus_a.hex0, bus_a.hex1, bus_a.wrap);
      cmp_inst(1, "B", bus_b.count_bin, bus_b.leds, bus_b.hex0, bus_b.hex1, bus_b.wrap);
   end

   // ---------------- stimulus helpers ----------------
   task automatic drv(input logic t);
      @(negedge clk);
      tick_r = t;
   endtask

   task automatic hold(input logic t, input int n);
      repeat (n) drv(t);
   endtask

   task automatic pulse();
      hold(1'b1, 4);
      hold(1'b0, 4);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #3;
   endtask

   initial begin
      int tick_left;
`ifdef LED_COUNT_DOWN_EN
      updn_r = 1'b1;
`else
      updn_r = 1'b0;
`endif
      // Reset with tick toggling, release while tick is high: no step.
      hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3);
      @(negedge clk); rst_n = 1'b1;
      hold(1'b1, 6);
      after_edge();
      chk("reset_count_b", 32'(bus_b.count_bin), 32'd0);
      chk("reset_hex0_b",  32'(bus_b.hex0), 32'h40);
      chk("reset_hex1_b",  32'(bus_b.hex1), 32'h40);
      chk("reset_wrap_a",  32'(bus_a.wrap), 32'd0);
      chk("reset_leds_a",  32'(bus_a.leds), 32'h00);

      // Single tick: count changes on the third edge after the rising sample.
      hold(1'b0, 4);
      drv(1'b1);
      repeat (3) after_edge();
      chk("latency_not_yet", 32'(bus_b.count_bin), 32'd0);
      after_edge();
      chk("single_tick_count", 32'(bus_b.count_bin), 32'd1);
      chk("single_tick_hex0",  32'(bus_b.hex0), 32'h79);
      hold(1'b1, 2); hold(1'b0, 6);
      chk("falling_no_step", 32'(bus_b.count_bin), 32'd1);

      // Wrap up on the MAX_COUNT=12 counter.
      repeat (11) pulse();
      after_edge();
      chk("at_max_count_a", 32'(bus_a.count_bin), 32'd12);
      chk("at_max_hex1_a",  32'(bus_a.hex1), 32'h79);
      chk("at_max_hex0_a",  32'(bus_a.hex0), 32'h24);
      drv(1'b1);
      repeat (3) after_edge();
      chk("pre_wrap_a", 32'(bus_a.wrap), 32'd0);
      after_edge();
      chk("wrap_count_a", 32'(bus_a.count_bin), 32'd0);
      chk("wrap_pulse_a", 32'(bus_a.wrap), 32'd1);
      chk("wrap_hex1_a",  32'(bus_a.hex1), 32'h40);
      chk("no_wrap_b",    32'(bus_b.wrap), 32'd0);
      chk("count_b_13",   32'(bus_b.count_bin), 32'd13);
      after_edge();
      chk("wrap_one_cycle_a", 32'(bus_a.wrap), 32'd0);
      hold(1'b1, 3); hold(1'b0, 4);

      // Priority: a step landing with clear is discarded.
      repeat (5) pulse();
      after_edge();
      chk("prio_start_a", 32'(bus_a.count_bin), 32'd5);
      drv(1'b1); drv(1'b1); drv(1'b1);
      @(negedge clk); clear_r = 1'b1;
      after_edge();
      chk("clear_step_count_a", 32'(bus_a.count_bin), 32'd0);
      chk("clear_step_wrap_a",  32'(bus_a.wrap), 32'd0);
      @(negedge clk); clear_r = 1'b0;
      hold(1'b1, 1); hold(1'b0, 6);
      chk("step_not_queued_b", 32'(bus_b.count_bin), 32'd0);

      // Pause drops ticks and shows on leds[7].
      @(negedge clk); pause_r = 1'b1;
      repeat (4) pulse();
      after_edge();
      chk("pause_count_a", 32'(bus_a.count_bin), 32'd0);
      chk("pause_leds_a",  32'(bus_a.leds), 32'h80);
      @(negedge clk); pause_r = 1'b0;
      pulse();
      after_edge();
      chk("resume_count_b", 32'(bus_b.count_bin), 32'd1);
      chk("resume_leds_a",  32'(bus_a.leds), 32'h01);

`ifdef LED_COUNT_DOWN_EN
      // Down from zero wraps to MAX_COUNT.
      @(negedge clk); rst_n = 1'b0; tick_r = 1'b0;
      @(negedge clk); rst_n = 1'b1; updn_r = 1'b0;
      hold(1'b0, 4);
      drv(1'b1);
      repeat (4) after_edge();
      chk("down_wrap_b",      32'(bus_b.count_bin), 32'd99);
      chk("down_wrap_hex0_b", 32'(bus_b.hex0), 32'h10);
      chk("down_wrap_hex1_b", 32'(bus_b.hex1), 32'h10);
      chk("down_wrap_pulse_b", 32'(bus_b.wrap), 32'd1);
      chk("down_wrap_a",      32'(bus_a.count_bin), 32'd12);
      hold(1'b1, 3); hold(1'b0, 4);
      pulse();
      after_edge();
      chk("down_98_b",      32'(bus_b.count_bin), 32'd98);
      chk("down_98_hex0_b", 32'(bus_b.hex0), 32'h00);
      updn_r = 1'b1;
`endif

      // Randomized phase: legal tick widths, random pause/clear/direction, two mid-run resets.
      tick_left = 3;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         @(negedge clk);
         if (tick_left == 0) begin
            tick_r    = ~tick_r;
            tick_left = $urandom_range(3, 10);
         end
         tick_left--;
         if ($urandom_range(0, 39) == 0) pause_r = ~pause_r;
         clear_r = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 99) == 0) updn_r = ~updn_r;
         rst_n = !(cyc == 1200 || cyc == 1201 || cyc == 2000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) after_edge();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
